lrrr_wave_ctrl: RTL and testbench
=================================

# lrrr_wave_ctrl

Lifecycle controller for the Lrrr boss sprite in the Space Invaders VGA path. It drives the movement block's start (`idleN`), dive (`toggleY`) and re-arm (`moveResetN`) inputs. It owns spawn delay, periodic dive commands, hit counting, the explosion phase and respawn. It sits between the game-state logic / collision detector and the Lrrr movement and draw blocks.

## Interface
Parameters:
- `SPAWN_DELAY`, default 90: frames in WAIT_SPAWN before launch; range 1..255.
- `TOGGLE_PERIOD`, default 45: frames between dive commands while ACTIVE; range 1..255.
- `EXPLODE_FRAMES`, default 30: frames in EXPLODE; range 1..255.
- `HIT_POINTS`, default 3: hits to kill; range 1..15.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-clock pulse per video frame.
- `gameEnable` in 1: level; high while the game runs.
- `hit` in 1: shot/Lrrr collision level; rising edge = one hit.
- `idleN` out 1: to movement block; rising edge launches Lrrr.
- `toggleY` out 1: to movement block; one-clock dive pulse.
- `moveResetN` out 1: to movement block reset; one-clock low pulse re-arms position and speed.
- `visible` out 1: draw enable for the Lrrr sprite.
- `exploding` out 1: draw enable for the explosion sprite.
- `killedPulse` out 1: one-clock pulse to score logic on kill.
- `hitsLeft` out 4: remaining hit points.

## Operation
- States are IDLE, WAIT_SPAWN, ACTIVE and EXPLODE. All outputs are registered.
- `frameCnt` (8 bit) clears on every state entry and increments on `startOfFrame`. A timed exit fires on the clock where `startOfFrame` is high and `frameCnt == DELAY-1`.
- IDLE: `idleN`=0, `visible`=0, `exploding`=0. Moves to WAIT_SPAWN when `gameEnable`=1. `hitsLeft` loads `HIT_POINTS`.
- WAIT_SPAWN: `idleN`=0, `visible`=0. Leaves after `SPAWN_DELAY` frames for ACTIVE. `idleN` goes 1 on the same edge as the state change.
- ACTIVE: `idleN`=1, `visible`=1. Every `TOGGLE_PERIOD` frames, `toggleY` is high for exactly one clock, the clock after the terminal `startOfFrame`.
  - Each `hit` rising edge decrements `hitsLeft`.
  - A hit when `hitsLeft`==1 sets `hitsLeft` to 0, pulses `killedPulse` and moves to EXPLODE.
- EXPLODE: `visible`=0, `exploding`=1, `idleN`=0. Leaves after `EXPLODE_FRAMES` frames for WAIT_SPAWN.
  - On that transition: `moveResetN` is low for one clock and `hitsLeft` reloads `HIT_POINTS`.
- `gameEnable`=0 in any non-IDLE state: next clock is IDLE, `moveResetN` is low for one clock, and `toggleY` and `killedPulse` stay 0.
- Hit rules:
  - `hit` edges outside ACTIVE are ignored.
  - A level held high counts once.
  - The `hit` edge detector register updates in every state.
- Simultaneous events:
  - `gameEnable` fall together with a killing hit: IDLE wins, no `killedPulse`.
  - Hit together with dive terminal frame: both take effect.
  - Kill together with dive terminal frame: EXPLODE, no `toggleY`.

## Timing
- Reset values: state IDLE, `frameCnt` 0, `idleN` 0, `toggleY` 0, `moveResetN` 1, `visible` 0, `exploding` 0, `killedPulse` 0, `hitsLeft` `HIT_POINTS`, hit-edge register 0.
- `hit` rising edge to `hitsLeft`/`killedPulse` update: 2 clocks (edge register plus output register).
- `gameEnable` rise to WAIT_SPAWN: 1 clock.
- WAIT_SPAWN entry to `idleN` rise: `SPAWN_DELAY` `startOfFrame` pulses, plus 0 clocks after the last pulse.
- `moveResetN` low pulse is exactly 1 clock. `idleN` stays 0 for at least `SPAWN_DELAY` frames afterwards, so the movement block sees a clean 0→1 edge.
- Reset asserted mid-operation: all state is lost immediately and the block restarts from IDLE.

## Configuration
- `LRRR_HITPOINTS_EN` defined:
  - Behaviour as above.
  - `hitsLeft` is a 4-bit down-counter.
- Not defined:
  - Any single hit in ACTIVE kills, regardless of `HIT_POINTS`.
  - `hitsLeft` reads 1 in IDLE, WAIT_SPAWN and ACTIVE, and 0 in EXPLODE.
  - No counter is synthesized.

## Structure
- Package `lrrr_pkg`:
  - `lrrr_state_t` enum (IDLE, WAIT_SPAWN, ACTIVE, EXPLODE).
  - `FRAME_CNT_W`=8.
  - `HP_W`=4.
- Sub-module `frame_timer`:
  - Counter with synchronous `clear`, `tick` (startOfFrame), `limit` input and `done` output.
  - Instantiated once and shared by all timed states.
  - Dive timing in ACTIVE reuses it with an auto-clear on `done`.

## Test plan
- Reset, `gameEnable`=1, `SPAWN_DELAY`=3 → `idleN` rises on the 3rd `startOfFrame` clock after WAIT_SPAWN entry; `visible`=1 from then on.
- ACTIVE with `TOGGLE_PERIOD`=2 for 6 frames → exactly 3 `toggleY` pulses, each 1 clock wide, each 1 clock after a `startOfFrame`.
- `HIT_POINTS`=3, three separate `hit` edges plus one held level → `hitsLeft` 3→2→1→0, single `killedPulse`, EXPLODE with `exploding`=1.
- After EXPLODE (`EXPLODE_FRAMES`=2) → 1-clock `moveResetN` low, `hitsLeft`=3, `idleN` low until the next spawn delay completes.
- `gameEnable` drops on the same clock as a killing hit → IDLE next clock, `moveResetN` pulse, no `killedPulse`, `hitsLeft` unchanged.
- Build without `LRRR_HITPOINTS_EN`, one `hit` edge in ACTIVE → immediate EXPLODE and `killedPulse`.

Source files
------------

// File: rtl/lrrr_pkg.sv
// lrrr_pkg: shared types and widths for the Lrrr boss lifecycle controller.
//   lrrr_state_t : lifecycle states (idle, spawn delay, active, exploding)
//   FRAME_CNT_W  : width of the shared frame timer
//   HP_W         : width of the hit-point counter / hitsLeft output
package lrrr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_SPAWN = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_EXPLODE    = 2'd3
  } lrrr_state_t;

  localparam int FRAME_CNT_W = 8;
  localparam int HP_W        = 4;

endpackage : lrrr_pkg

// File: rtl/lrrr_wave_ctrl_frame_timer.sv
// frame_timer: frame counter shared by every timed state of the Lrrr controller.
//   clk, resetN : clock, async active-low reset
//   clear       : synchronous clear (wins over tick)
//   tick        : one-clock frame pulse (startOfFrame)
//   limit       : number of frames for the current timed interval
//   done        : high on the tick that completes the interval (combinational)
module frame_timer
  import lrrr_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   clear,
  input  logic                   tick,
  input  logic [FRAME_CNT_W-1:0] limit,
  output logic                   done
);

  logic [FRAME_CNT_W-1:0] cnt_q;
  logic [FRAME_CNT_W-1:0] cnt_d;

  // next count: clear has priority over a frame tick
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = cnt_q + FRAME_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // the interval ends on the frame pulse that would take the count to limit
  assign done = tick && (cnt_q == (limit - FRAME_CNT_W'(1)));

endmodule : frame_timer

// File: rtl/lrrr_wave_ctrl.sv
// lrrr_wave_ctrl: lifecycle controller for the Lrrr boss sprite.
// Sequences spawn delay, periodic dives, hit counting, explosion and respawn,
// and drives the movement block (idleN, toggleY, moveResetN) and draw enables.
//   clk, resetN   : clock, async active-low reset
//   startOfFrame  : one-clock pulse per video frame
//   gameEnable    : level, game running
//   hit           : collision level, rising edge = one hit
//   idleN         : rising edge launches Lrrr
//   toggleY       : one-clock dive pulse
//   moveResetN    : one-clock low pulse re-arms the movement block
//   visible       : Lrrr sprite draw enable
//   exploding     : explosion sprite draw enable
//   killedPulse   : one-clock pulse on kill
//   hitsLeft      : remaining hit points
// Build option LRRR_HITPOINTS_EN: when defined, hitsLeft is a real down-counter
// loaded from HIT_POINTS; when undefined any single hit kills and hitsLeft only
// reads 1 (alive) or 0 (exploding).
module lrrr_wave_ctrl
  import lrrr_pkg::*;
#(
  parameter int SPAWN_DELAY    = 90,
  parameter int TOGGLE_PERIOD  = 45,
  parameter int EXPLODE_FRAMES = 30,
  parameter int HIT_POINTS     = 3
) (
  input  logic            clk,
  input  logic            resetN,
  input  logic            startOfFrame,
  input  logic            gameEnable,
  input  logic            hit,
  output logic            idleN,
  output logic            toggleY,
  output logic            moveResetN,
  output logic            visible,
  output logic            exploding,
  output logic            killedPulse,
  output logic [HP_W-1:0] hitsLeft
);

  localparam logic [HP_W-1:0] HP_LOAD = HP_W'(HIT_POINTS);

  lrrr_state_t state_q, state_d;
  logic hit_q, hit_rise_q;
  logic idle_n_q, idle_n_d;
  logic toggle_y_q, toggle_y_d;
  logic move_reset_n_q, move_reset_n_d;
  logic visible_q, visible_d;
  logic exploding_q, exploding_d;
  logic killed_q, killed_d;
  logic [HP_W-1:0] hits_left_q, hits_left_d;

  logic                   timer_clear;
  logic                   timer_done;
  logic [FRAME_CNT_W-1:0] timer_limit;
  logic                   hit_evt;
  logic                   kill_hit;

  // registered edge pulse: hits act two clocks after the input edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_q      <= 1'b0;
      hit_rise_q <= 1'b0;
    end else begin
      hit_q      <= hit;
      hit_rise_q <= hit & ~hit_q;
    end
  end

  assign hit_evt = (state_q == ST_ACTIVE) && hit_rise_q;

`ifdef LRRR_HITPOINTS_EN
  assign kill_hit = hit_evt && (hits_left_q == HP_W'(1));
`else
  assign kill_hit = hit_evt;
`endif

  // timer interval for the current state
  always_comb begin
    timer_limit = '0;
    case (state_q)
      ST_WAIT_SPAWN: timer_limit = FRAME_CNT_W'(SPAWN_DELAY);
      ST_ACTIVE:     timer_limit = FRAME_CNT_W'(TOGGLE_PERIOD);
      ST_EXPLODE:    timer_limit = FRAME_CNT_W'(EXPLODE_FRAMES);
      default:       timer_limit = '0;
    endcase
  end

  // restart the count on every state entry; in ACTIVE it also re-arms each dive period
  assign timer_clear = (state_d != state_q) || (state_q == ST_IDLE) ||
                       ((state_q == ST_ACTIVE) && timer_done);

  frame_timer u_frame_timer (
    .clk    (clk),
    .resetN (resetN),
    .clear  (timer_clear),
    .tick   (startOfFrame),
    .limit  (timer_limit),
    .done   (timer_done)
  );

  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: losing gameEnable beats every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (gameEnable) state_d = ST_WAIT_SPAWN;
        else            state_d = ST_IDLE;
      end
      ST_WAIT_SPAWN: begin
        if (!gameEnable)     state_d = ST_IDLE;
        else if (timer_done) state_d = ST_ACTIVE;
        else                 state_d = ST_WAIT_SPAWN;
      end
      ST_ACTIVE: begin
        if (!gameEnable)   state_d = ST_IDLE;
        else if (kill_hit) state_d = ST_EXPLODE;
        else               state_d = ST_ACTIVE;
      end
      ST_EXPLODE: begin
        if (!gameEnable)     state_d = ST_IDLE;
        else if (timer_done) state_d = ST_WAIT_SPAWN;
        else                 state_d = ST_EXPLODE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // output next values, derived from the transition so outputs change with the state
  always_comb begin
    idle_n_d    = (state_d == ST_ACTIVE);
    visible_d   = (state_d == ST_ACTIVE);
    exploding_d = (state_d == ST_EXPLODE);
    // a dive pulse only while staying in ACTIVE, so a kill suppresses it
    toggle_y_d  = (state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && timer_done;
    killed_d    = kill_hit && (state_d == ST_EXPLODE);
    move_reset_n_d = !(((state_q != ST_IDLE) && (state_d == ST_IDLE)) ||
                       ((state_q == ST_EXPLODE) && (state_d == ST_WAIT_SPAWN)));
`ifdef LRRR_HITPOINTS_EN
    if (state_q == ST_IDLE) begin
      hits_left_d = HP_LOAD;
    end else if (state_d == ST_IDLE) begin
      hits_left_d = hits_left_q;
    end else if ((state_q == ST_EXPLODE) && (state_d == ST_WAIT_SPAWN)) begin
      hits_left_d = HP_LOAD;
    end else if (hit_evt) begin
      hits_left_d = hits_left_q - HP_W'(1);
    end else begin
      hits_left_d = hits_left_q;
    end
`else
    if (state_d == ST_EXPLODE) begin
      hits_left_d = HP_W'(0);
    end else begin
      hits_left_d = HP_W'(1);
    end
`endif
  end

  // output registers; hitsLeft resets to HIT_POINTS and settles on the first IDLE clock
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      idle_n_q       <= 1'b0;
      toggle_y_q     <= 1'b0;
      move_reset_n_q <= 1'b1;
      visible_q      <= 1'b0;
      exploding_q    <= 1'b0;
      killed_q       <= 1'b0;
      hits_left_q    <= HP_LOAD;
    end else begin
      idle_n_q       <= idle_n_d;
      toggle_y_q     <= toggle_y_d;
      move_reset_n_q <= move_reset_n_d;
      visible_q      <= visible_d;
      exploding_q    <= exploding_d;
      killed_q       <= killed_d;
      hits_left_q    <= hits_left_d;
    end
  end

  assign idleN       = idle_n_q;
  assign toggleY     = toggle_y_q;
  assign moveResetN  = move_reset_n_q;
  assign visible     = visible_q;
  assign exploding   = exploding_q;
  assign killedPulse = killed_q;
  assign hitsLeft    = hits_left_q;

endmodule : lrrr_wave_ctrl

// File: tb/tb_lrrr_wave_ctrl.sv
// tb_lrrr_wave_ctrl: directed bench for lrrr_wave_ctrl with short timing parameters.
// Works for both builds of LRRR_HITPOINTS_EN; expected hitsLeft values follow the build.
module tb_lrrr_wave_ctrl;

  localparam int SD = 3;
  localparam int TP = 2;
  localparam int EF = 2;
  localparam int HP = 3;
`ifdef LRRR_HITPOINTS_EN
  localparam logic [3:0] HP_RD   = 4'd3;
  localparam logic [3:0] HL_DIVE = 4'd2;
  localparam logic       KILL_ON_DIVE = 1'b0;
`else
  localparam logic [3:0] HP_RD   = 4'd1;
  localparam logic [3:0] HL_DIVE = 4'd0;
  localparam logic       KILL_ON_DIVE = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       gameEnable = 1'b0;
  logic       hit = 1'b0;
  logic       idleN, toggleY, moveResetN, visible, exploding, killedPulse;
  logic [3:0] hitsLeft;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lrrr_wave_ctrl #(
    .SPAWN_DELAY(SD), .TOGGLE_PERIOD(TP), .EXPLODE_FRAMES(EF), .HIT_POINTS(HP)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .gameEnable(gameEnable),
    .hit(hit), .idleN(idleN), .toggleY(toggleY), .moveResetN(moveResetN),
    .visible(visible), .exploding(exploding), .killedPulse(killedPulse), .hitsLeft(hitsLeft)
  );

  // expected output vector {idleN,toggleY,moveResetN,visible,exploding,killedPulse,hitsLeft}
  function automatic logic [9:0] ex(input logic i, input logic t, input logic m, input logic v,
                                    input logic e, input logic k, input logic [3:0] h);
    return {i, t, m, v, e, k, h};
  endfunction

  typedef struct packed {
    logic       sof;
    logic       ge;
    logic       hit;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [9:0] e);
    logic [9:0] got;
    got = {idleN, toggleY, moveResetN, visible, exploding, killedPulse, hitsLeft};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got {idleN,toggleY,moveResetN,visible,exploding,killed,hitsLeft}=%b required=%b",
               name, got, e);
    end
  endtask

  // drive one clock of inputs, then sample 1 time unit after the edge
  task automatic step(input logic s, input logic g, input logic h);
    startOfFrame = s;
    gameEnable   = g;
    hit          = h;
    @(posedge clk);
    #1;
  endtask

  // WAIT_SPAWN entry from IDLE, then SD frames to launch
  task automatic spawn(input string tag);
    step(1'b0, 1'b1, 1'b0);
    chk({tag, "_wait"}, ex(0, 0, 1, 0, 0, 0, HP_RD));
    for (int f = 1; f <= SD; f++) begin
      step(1'b1, 1'b1, 1'b0);
      if (f < SD) chk($sformatf("%s_sof%0d", tag, f), ex(0, 0, 1, 0, 0, 0, HP_RD));
      else        chk($sformatf("%s_launch", tag), ex(1, 0, 1, 1, 0, 0, HP_RD));
    end
  endtask

  // non-killing hit pulses taking hitsLeft from HP_RD down to 1 (none in the default build)
  task automatic hit_down(input string tag);
    for (int k = int'(HP_RD); k > 1; k--) begin
      step(1'b0, 1'b1, 1'b1);
      chk($sformatf("%s_edge%0d", tag, k), ex(1, 0, 1, 1, 0, 0, 4'(k)));
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("%s_dec%0d", tag, k), ex(1, 0, 1, 1, 0, 0, 4'(k - 1)));
    end
  endtask

  initial begin
    // spawn and dive timing from reset
    tbl[0]  = '{1'b0, 1'b1, 1'b0, ex(0, 0, 1, 0, 0, 0, HP_RD)};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, ex(0, 0, 1, 0, 0, 0, HP_RD)};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, ex(0, 0, 1, 0, 0, 0, HP_RD)};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, ex(0, 0, 1, 0, 0, 0, HP_RD)};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, ex(0, 0, 1, 0, 0, 0, HP_RD)};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, ex(1, 1, 1, 1, 0, 0, HP_RD)};
    tbl[10] = '{1'b0, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[11] = '{1'b1, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[12] = '{1'b1, 1'b1, 1'b0, ex(1, 1, 1, 1, 0, 0, HP_RD)};
    tbl[13] = '{1'b0, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[14] = '{1'b1, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};
    tbl[15] = '{1'b1, 1'b1, 1'b0, ex(1, 1, 1, 1, 0, 0, HP_RD)};
    tbl[16] = '{1'b0, 1'b1, 1'b0, ex(1, 0, 1, 1, 0, 0, HP_RD)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset", ex(0, 0, 1, 0, 0, 0, 4'(HP)));
    resetN = 1'b1;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].sof, tbl[i].ge, tbl[i].hit);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // hits down to the kill; the killing level is held and counts once
    hit_down("hits");
    step(1'b0, 1'b1, 1'b1);
    chk("kill_edge", ex(1, 0, 1, 1, 0, 0, 4'd1));
    step(1'b0, 1'b1, 1'b1);
    chk("kill", ex(0, 0, 1, 0, 1, 1, 4'd0));
    step(1'b0, 1'b1, 1'b1);
    chk("kill_held", ex(0, 0, 1, 0, 1, 0, 4'd0));
    step(1'b0, 1'b1, 1'b0);
    chk("explode0", ex(0, 0, 1, 0, 1, 0, 4'd0));
    step(1'b1, 1'b1, 1'b0);
    chk("explode1", ex(0, 0, 1, 0, 1, 0, 4'd0));
    step(1'b1, 1'b1, 1'b0);
    chk("rearm", ex(0, 0, 0, 0, 0, 0, HP_RD));
    step(1'b0, 1'b1, 1'b0);
    chk("rearm_end", ex(0, 0, 1, 0, 0, 0, HP_RD));
    // hit while waiting to spawn is ignored
    step(1'b0, 1'b1, 1'b1);
    chk("wait_hit", ex(0, 0, 1, 0, 0, 0, HP_RD));
    step(1'b0, 1'b1, 1'b0);
    chk("wait_hit2", ex(0, 0, 1, 0, 0, 0, HP_RD));
    for (int f = 1; f <= SD; f++) begin
      step(1'b1, 1'b1, 1'b0);
      if (f < SD) chk($sformatf("respawn%0d", f), ex(0, 0, 1, 0, 0, 0, HP_RD));
      else        chk("respawn", ex(1, 0, 1, 1, 0, 0, HP_RD));
    end

    // hit on the dive terminal frame (a kill in the default build)
    step(1'b1, 1'b1, 1'b0);
    chk("dive_pre", ex(1, 0, 1, 1, 0, 0, HP_RD));
    step(1'b0, 1'b1, 1'b1);
    chk("dive_hit_edge", ex(1, 0, 1, 1, 0, 0, HP_RD));
    step(1'b1, 1'b1, 1'b1);
    if (KILL_ON_DIVE) chk("dive_kill", ex(0, 0, 1, 0, 1, 1, HL_DIVE));
    else              chk("dive_hit", ex(1, 1, 1, 1, 0, 0, HL_DIVE));
    step(1'b0, 1'b1, 1'b0);
    if (KILL_ON_DIVE) chk("dive_kill_after", ex(0, 0, 1, 0, 1, 0, HL_DIVE));
    else              chk("dive_hit_after", ex(1, 0, 1, 1, 0, 0, HL_DIVE));

    // game disable from ACTIVE/EXPLODE
    step(1'b0, 1'b0, 1'b0);
    chk("ge_drop", ex(0, 0, 0, 0, 0, 0, KILL_ON_DIVE ? 4'd1 : HL_DIVE));
    step(1'b0, 1'b0, 1'b0);
    chk("ge_idle", ex(0, 0, 1, 0, 0, 0, HP_RD));

    // killing hit together with gameEnable fall: IDLE wins
    spawn("sp2");
    hit_down("hd2");
    step(1'b0, 1'b1, 1'b1);
    chk("gk_edge", ex(1, 0, 1, 1, 0, 0, 4'd1));
    step(1'b0, 1'b0, 1'b0);
    chk("gk_idle", ex(0, 0, 0, 0, 0, 0, 4'd1));
    step(1'b0, 1'b0, 1'b0);
    chk("gk_after", ex(0, 0, 1, 0, 0, 0, HP_RD));

    // asynchronous reset in the middle of ACTIVE
    spawn("sp3");
    step(1'b1, 1'b1, 1'b1);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_reset", ex(0, 0, 1, 0, 0, 0, 4'(HP)));
    step(1'b1, 1'b1, 1'b0);
    chk("held_reset", ex(0, 0, 1, 0, 0, 0, 4'(HP)));
    resetN = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("post_reset_idle", ex(0, 0, 1, 0, 0, 0, HP_RD));
    spawn("sp4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_lrrr_wave_ctrl
